// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  sound_pkg
//  Shared sound constants and the envelope state type for the tone path.
//  Revision: 1.0
// ============================================================================
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    localparam int unsigned DEF_CLK_HZ     = 50_000_000;
    localparam int unsigned DEF_SAMPLE_HZ  = 48_000;
    localparam logic [15:0] DEF_AMP_MAX    = 16'd24000;
    localparam int unsigned DEF_RAMP_STEPS = 16;

    localparam int unsigned SAMPLE_DIV = DEF_CLK_HZ / DEF_SAMPLE_HZ;
    localparam int unsigned AMP_STEP   = 32'(DEF_AMP_MAX) / DEF_RAMP_STEPS;

    localparam logic [9:0] LOSE_FREQ = 10'd950;
    localparam logic [9:0] WIN_FREQ  = 10'd500;

    localparam int unsigned ACC_W = 27;

endpackage
`default_nettype wire

// File: rtl/tone_synth_if.sv
`default_nettype none
// ============================================================================
//  tone_synth_if
//  Tone request inputs and sample-stream handshake of the tone synthesizer.
//  Revision: 1.0
// ============================================================================
interface tone_synth_if;
    logic               enable_sound;
    logic        [9:0]  sound_freq;
    logic               sample_ready;
    logic               sample_valid;
    logic signed [15:0] sample;
    logic               busy;
    logic               overrun;

    modport master (
        output enable_sound, sound_freq, sample_ready,
        input  sample_valid, sample, busy, overrun
    );

    modport slave (
        input  enable_sound, sound_freq, sample_ready,
        output sample_valid, sample, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/tone_synth_osc.sv
`default_nettype none
// ============================================================================
//  square_osc
//  Phase-accumulator square oscillator with latched frequency.
//  Revision: 1.0
// ============================================================================
module square_osc
    import sound_pkg::*;
#(
    parameter int unsigned HALF_CLK = DEF_CLK_HZ / 2
) (
    input  wire logic       clk,
    input  wire logic       resetN,
    input  wire logic       load,
    input  wire logic       clear,
    input  wire logic [9:0] freq,
    output logic            polarity,
    output logic            freq_zero
);

    localparam logic [ACC_W:0] c_half = (ACC_W+1)'(HALF_CLK);

    logic [ACC_W-1:0] r_acc;
    logic [9:0]       r_freq_q;
    logic             r_pol;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {{(ACC_W-9){1'b0}}, r_freq_q};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_acc    <= '0;
            r_freq_q <= '0;
            r_pol    <= 1'b0;
        end else begin
            if (load) begin
                r_freq_q <= freq;
            end
            // acc stays below half, so a zero frequency never toggles
            if (clear) begin
                r_acc <= '0;
                r_pol <= 1'b0;
            end else if (w_sum >= c_half) begin
                r_acc <= ACC_W'(w_sum - c_half);
                r_pol <= ~r_pol;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign polarity  = r_pol;
    assign freq_zero = (r_freq_q == 10'd0);

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
//  tone_synth
//  Square-wave tone generator with linear attack/release envelope and a
//  fixed-rate valid/ready PCM sample output.
//  Revision: 1.0
// ============================================================================
module tone_synth
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned SAMPLE_HZ  = DEF_SAMPLE_HZ,
    parameter logic [15:0] AMP_MAX    = DEF_AMP_MAX,
    parameter int unsigned RAMP_STEPS = DEF_RAMP_STEPS
) (
    input  wire logic   clk,
    input  wire logic   resetN,
    tone_synth_if.slave snd
);

    localparam int unsigned c_div      = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned c_div_w    = $clog2(c_div);
    localparam int unsigned c_lvl_w    = $clog2(RAMP_STEPS) + 1;
    localparam logic [15:0] c_amp_step = 16'(32'(AMP_MAX) / RAMP_STEPS);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_lvl_w-1:0] c_ramp     = c_lvl_w'(RAMP_STEPS);
    localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);

    env_state_t         r_state;
    logic [c_lvl_w-1:0] r_level;
    logic               r_busy;
    logic [c_div_w-1:0] r_div;
    logic               r_valid;
    logic [15:0]        r_sample;
    logic               r_overrun;

    logic        w_tick;
    logic        w_load;
    logic        w_clear;
    logic        w_pol;
    logic        w_freq_zero;
    logic [15:0] w_amp;
    logic [15:0] w_next;

    square_osc #(
        .HALF_CLK (CLK_HZ / 2)
    ) u_osc (
        .clk       (clk),
        .resetN    (resetN),
        .load      (w_load),
        .clear     (w_clear),
        .freq      (snd.sound_freq),
        .polarity  (w_pol),
        .freq_zero (w_freq_zero)
    );

    // Frequency is relatched whenever a request (re)starts the attack
    assign w_clear = (r_state == ST_IDLE) && snd.enable_sound;
    assign w_load  = w_clear || ((r_state == ST_RELEASE) && snd.enable_sound);

    assign w_tick = (r_div == c_div_last);

    always_ff @(posedge clk) begin
        if (!resetN || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_level <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (snd.enable_sound) begin
                        r_state <= ST_ATTACK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ATTACK: begin
                    if (!snd.enable_sound) begin
                        r_state <= ST_RELEASE;
                    end else if (r_level >= c_ramp) begin
                        r_state <= ST_SUSTAIN;
                    end else if (w_tick) begin
                        r_level <= r_level + c_lvl_one;
                        if (r_level + c_lvl_one == c_ramp) begin
                            r_state <= ST_SUSTAIN;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    if (!snd.enable_sound) begin
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (snd.enable_sound) begin
                        r_state <= ST_ATTACK;
                    end else if (w_tick) begin
                        // a level of 0 or 1 finishes here so a tick-less pulse still ends
                        if (r_level <= c_lvl_one) begin
                            r_level <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_level <= r_level - c_lvl_one;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_level <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_amp  = 16'(r_level) * c_amp_step;
    assign w_next = w_freq_zero ? 16'd0 : (w_pol ? (16'd0 - w_amp) : w_amp);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_valid   <= 1'b0;
            r_sample  <= '0;
            r_overrun <= 1'b0;
        end else if (w_tick) begin
            if (r_valid && !snd.sample_ready) begin
                r_overrun <= 1'b1;
            end else begin
                r_valid  <= 1'b1;
                r_sample <= w_next;
            end
        end else if (r_valid && snd.sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign snd.sample_valid = r_valid;
    assign snd.sample       = $signed(r_sample);
    assign snd.busy         = r_busy;
    assign snd.overrun      = r_overrun;

endmodule
`default_nettype wire
